// File: rtl/jk_bank_driver_if.sv
// Command channel into the JK bank driver.
// Valid/ready handshake plus the command payload.
interface jk_bank_driver_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_mask;
  logic [WIDTH-1:0] cmd_data;
  logic [CNT_W-1:0] cmd_count;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_mask,
    output cmd_data,
    output cmd_count,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_mask,
    input  cmd_data,
    input  cmd_count,
    output cmd_ready
  );
endinterface

// File: rtl/jk_bank_driver.sv
// Drives j/k of a bank of JK flip-flops from register commands.
// JK_BANK_DRIVER_VERIFY_EN adds read-back self-verification.
module jk_bank_driver #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  jk_bank_driver_if.slave  cmd,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_SET = 3'd1;
  localparam logic [2:0] OP_CLR = 3'd2;
  localparam logic [2:0] OP_TGL = 3'd3;
  localparam logic [2:0] OP_LD  = 3'd4;
  localparam logic [2:0] OP_INC = 3'd5;
  localparam logic [2:0] OP_DEC = 3'd6;
  localparam logic [2:0] OP_CHK = 3'd7;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    STEP_DRIVE,
    STEP_SETTLE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] j_q, j_d;
  logic [WIDTH-1:0] k_q, k_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef JK_BANK_DRIVER_VERIFY_EN
  logic [WIDTH-1:0] exp_q, exp_d;
`endif

  logic accept;
  logic dn_q;

  // Toggle mask for a counter step: every bit below the
  // first 0 (INC) or first 1 (DEC), plus that bit.
  function automatic logic [WIDTH-1:0] step_t(
    input logic             dn,
    input logic [WIDTH-1:0] q
  );
    logic [WIDTH-1:0] t;
    t[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++)
      t[i] = t[i-1] & (dn ? ~q[i-1] : q[i-1]);
    return t;
  endfunction

`ifdef JK_BANK_DRIVER_VERIFY_EN
  // Value the bank should hold after a masked op.
  function automatic logic [WIDTH-1:0] apply_op(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] q,
    input logic [WIDTH-1:0] m,
    input logic [WIDTH-1:0] d
  );
    logic [WIDTH-1:0] r;
    r = q;
    case (op)
      OP_SET:  r = q | m;
      OP_CLR:  r = q & ~m;
      OP_TGL:  r = q ^ m;
      OP_LD:   r = (q & ~m) | (d & m);
      default: r = q;
    endcase
    return r;
  endfunction
`endif

  assign cmd.cmd_ready = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign accept        = cmd.cmd_valid & cmd.cmd_ready;
  assign dn_q          = (op_q == OP_DEC);
  assign j             = j_q;
  assign k             = k_q;
  assign done          = done_q;
  assign err           = err_q;

  // Next-state, j/k pattern and error tracking.
  always_comb begin
    state_d = state_q;
    j_d     = '0;
    k_d     = '0;
    done_d  = 1'b0;
    err_d   = err_q;
    op_d    = op_q;
    mask_d  = mask_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
`ifdef JK_BANK_DRIVER_VERIFY_EN
    exp_d   = exp_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op_d   = cmd.cmd_op;
          mask_d = cmd.cmd_mask;
          data_d = cmd.cmd_data;
          cnt_d  = cmd.cmd_count;
          if ((cmd.cmd_op == OP_INC ||
               cmd.cmd_op == OP_DEC) &&
              cmd.cmd_count != '0) begin
            state_d = STEP_DRIVE;
            j_d = step_t(cmd.cmd_op == OP_DEC, q_fb);
            k_d = j_d;
`ifdef JK_BANK_DRIVER_VERIFY_EN
            exp_d = (cmd.cmd_op == OP_DEC) ?
                    q_fb - WIDTH'(1) : q_fb + WIDTH'(1);
`endif
          end else begin
            state_d = DRIVE;
            case (cmd.cmd_op)
              OP_SET: j_d = cmd.cmd_mask;
              OP_CLR: k_d = cmd.cmd_mask;
              OP_TGL: begin
                j_d = cmd.cmd_mask;
                k_d = cmd.cmd_mask;
              end
              OP_LD: begin
                j_d = cmd.cmd_data & cmd.cmd_mask;
                k_d = ~cmd.cmd_data & cmd.cmd_mask;
              end
              OP_NOP:  err_d = 1'b0;
              default: ;
            endcase
`ifdef JK_BANK_DRIVER_VERIFY_EN
            exp_d = apply_op(cmd.cmd_op, q_fb,
                             cmd.cmd_mask, cmd.cmd_data);
`endif
          end
        end
      end
      DRIVE: begin
        state_d = SETTLE;
        done_d  = 1'b1;
      end
      SETTLE: begin
        state_d = IDLE;
        if (op_q == OP_CHK &&
            ((q_fb ^ data_q) & mask_q) != '0)
          err_d = 1'b1;
`ifdef JK_BANK_DRIVER_VERIFY_EN
        if (op_q >= OP_SET && op_q <= OP_LD &&
            q_fb != exp_q)
          err_d = 1'b1;
`endif
      end
      STEP_DRIVE: begin
        state_d = STEP_SETTLE;
        done_d  = (cnt_q == CNT_W'(1));
      end
      STEP_SETTLE: begin
        cnt_d = cnt_q - CNT_W'(1);
`ifdef JK_BANK_DRIVER_VERIFY_EN
        if (q_fb != exp_q)
          err_d = 1'b1;
        exp_d = dn_q ? q_fb - WIDTH'(1) :
                       q_fb + WIDTH'(1);
`endif
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
        end else begin
          state_d = STEP_DRIVE;
          j_d = step_t(dn_q, q_fb);
          k_d = j_d;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset drops any pattern.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      j_q     <= '0;
      k_q     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      op_q    <= OP_NOP;
      mask_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
`ifdef JK_BANK_DRIVER_VERIFY_EN
      exp_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      k_q     <= k_d;
      done_q  <= done_d;
      err_q   <= err_d;
      op_q    <= op_d;
      mask_q  <= mask_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
`ifdef JK_BANK_DRIVER_VERIFY_EN
      exp_q   <= exp_d;
`endif
    end
  end

endmodule

// File: tb/tb_jk_bank_driver.sv
// Testbench for jk_bank_driver: JK bank model plus
// a register-level reference of the bank contents.
module tb_jk_bank_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       stuck = 1'b0;
  logic [7:0] bank_q = 8'h00;
  logic [7:0] q_fb;
  logic [7:0] j, k;
  logic       busy, done, err;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] model_q = 8'h00;
  logic       err_m = 1'b0;

  jk_bank_driver_if #(.WIDTH(8), .CNT_W(8)) bus ();

  jk_bank_driver #(.WIDTH(8), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (rst),
    .cmd   (bus),
    .q_fb  (q_fb),
    .j     (j),
    .k     (k),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  assign q_fb = stuck ? 8'h00 : bank_q;

  // The flip-flop bank itself.
  always @(posedge clk) begin
    for (int i = 0; i < 8; i++)
      case ({j[i], k[i]})
        2'b10: bank_q[i] <= 1'b1;
        2'b01: bank_q[i] <= 1'b0;
        2'b11: bank_q[i] <= ~bank_q[i];
        default: ;
      endcase
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_q(
    input logic [2:0] op, input logic [7:0] q,
    input logic [7:0] m, input logic [7:0] d,
    input logic [7:0] n);
    case (op)
      3'd1: return q | m;
      3'd2: return q & ~m;
      3'd3: return q ^ m;
      3'd4: return (q & ~m) | (d & m);
      3'd5: return q + n;
      3'd6: return q - n;
      default: return q;
    endcase
  endfunction

  task automatic drive_cmd(input logic [2:0] op,
                           input logic [7:0] m,
                           input logic [7:0] d,
                           input logic [7:0] n);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_mask  = m;
    bus.cmd_data  = d;
    bus.cmd_count = n;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'($urandom);
    bus.cmd_mask  = 8'($urandom);
    bus.cmd_data  = 8'($urandom);
    bus.cmd_count = 8'($urandom);
  endtask

  // Issue one command at a negedge and check every cycle.
  task automatic do_cmd(input logic [2:0] op,
                        input logic [7:0] m,
                        input logic [7:0] d,
                        input logic [7:0] n);
    bit         step;
    int         lat;
    logic [7:0] cur, nxt, ej, ek;
    chk("ready_pre", bus.cmd_ready, 1);
    step = (op == 3'd5 || op == 3'd6) && n != 0;
    lat  = step ? 2 * n : 2;
    cur  = model_q;
    if (op == 3'd0) err_m = 1'b0;
    if (op == 3'd7 && ((model_q ^ d) & m) != 0)
      err_m = 1'b1;
    drive_cmd(op, m, d, n);
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      ej = 8'h00;
      ek = 8'h00;
      if (step) begin
        nxt = (op == 3'd5) ? cur + 8'd1 : cur - 8'd1;
        if (c % 2 == 1) begin
          ej = cur ^ nxt;
          ek = cur ^ nxt;
        end else begin
          cur = nxt;
        end
      end else if (c == 1) begin
        case (op)
          3'd1: ej = m;
          3'd2: ek = m;
          3'd3: begin ej = m; ek = m; end
          3'd4: begin ej = d & m; ek = ~d & m; end
          default: ;
        endcase
      end
      chk("j", j, ej);
      chk("k", k, ek);
      chk("busy", busy, 1);
      chk("done", done, c == lat);
    end
    model_q = ref_q(op, model_q, m, d, n);
    @(negedge clk);
    chk("ready_post", bus.cmd_ready, 1);
    chk("busy_post", busy, 0);
    chk("done_post", done, 0);
    chk("q", q_fb, model_q);
    chk("err", err, err_m);
  endtask

  initial begin
    logic [2:0] op;
    logic [7:0] m, d, n;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_mask  = 8'h00;
    bus.cmd_data  = 8'h00;
    bus.cmd_count = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_j", j, 0);
    chk("rst_k", k, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", bus.cmd_ready, 1);
    rst = 1'b0;
    @(negedge clk);

    do_cmd(3'd4, 8'hFF, 8'hA5, 8'h00);
    chk("load_a5", q_fb, 8'hA5);
    do_cmd(3'd3, 8'h0F, 8'h00, 8'h00);
    chk("tgl_aa", q_fb, 8'hAA);
    do_cmd(3'd1, 8'h40, 8'h00, 8'h00);
    chk("set_ea", q_fb, 8'hEA);
    do_cmd(3'd2, 8'h80, 8'h00, 8'h00);
    chk("clr_6a", q_fb, 8'h6A);
    do_cmd(3'd4, 8'hFF, 8'hFE, 8'h00);
    do_cmd(3'd5, 8'h00, 8'h00, 8'd3);
    chk("inc_wrap", q_fb, 8'h01);
    do_cmd(3'd4, 8'hFF, 8'h00, 8'h00);
    do_cmd(3'd6, 8'h00, 8'h00, 8'd2);
    chk("dec_wrap", q_fb, 8'hFE);
    do_cmd(3'd4, 8'hFF, 8'h01, 8'h00);
    do_cmd(3'd7, 8'hFF, 8'h00, 8'h00);
    chk("chk_err", err, 1);
    do_cmd(3'd1, 8'h10, 8'h00, 8'h00);
    chk("err_sticky", err, 1);
    do_cmd(3'd5, 8'h00, 8'h00, 8'd0);
    chk("inc0_keeps_err", err, 1);
    do_cmd(3'd0, 8'h00, 8'h00, 8'h00);
    chk("nop_clr", err, 0);

    // Reset in the middle of step 2 of INC by 5.
    do_cmd(3'd4, 8'hFF, 8'h10, 8'h00);
    drive_cmd(3'd5, 8'h00, 8'h00, 8'd5);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_j", j, 0);
    chk("mid_k", k, 0);
    chk("mid_busy", busy, 0);
    chk("mid_ready", bus.cmd_ready, 1);
    model_q = 8'h11;
    err_m   = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_q", q_fb, model_q);
    do_cmd(3'd3, 8'hFF, 8'h00, 8'h00);

    // Stuck read-back: only the verifying build flags it.
    do_cmd(3'd4, 8'hFF, 8'h00, 8'h00);
    stuck = 1'b1;
    drive_cmd(3'd1, 8'h01, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
`ifdef JK_BANK_DRIVER_VERIFY_EN
    chk("stuck_err", err, 1);
`else
    chk("stuck_err", err, 0);
`endif
    stuck   = 1'b0;
    model_q = 8'h01;
    do_cmd(3'd0, 8'h00, 8'h00, 8'h00);

    for (int i = 0; i < 150; i++) begin
      op = 3'($urandom);
      m  = 8'($urandom);
      d  = 8'($urandom);
      n  = 8'($urandom_range(0, 5));
      if (op == 3'd7 && $urandom_range(0, 1) == 1)
        d = model_q;
      do_cmd(op, m, d, n);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/jk_bank_driver.md
Name: jk_bank_driver

Overview:
- Control stage directly upstream of a bank of WIDTH flipflop_jk cells; generates their per-bit j/k inputs.
- Accepts register-level commands over a valid/ready handshake: set, clear, toggle, load, increment/decrement by N, check.
- Translates each command into one or more single-cycle J/K patterns.
- Reads the bank's q outputs back for counting, checking and optional self-verification.

Parameters:
- WIDTH, 8, number of JK flip-flops driven.
- CNT_W, 8, width of the step count for INC/DEC.

Ports:
- clk  in  1  system clock; the bank samples j/k on the same posedge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  driver can accept a command.
- cmd_op  in  3  opcode: 0 NOP/ERRCLR, 1 SET, 2 CLEAR, 3 TOGGLE, 4 LOAD, 5 INC, 6 DEC, 7 CHECK.
- cmd_mask  in  WIDTH  bit select for SET/CLEAR/TOGGLE/LOAD/CHECK.
- cmd_data  in  WIDTH  value for LOAD/CHECK.
- cmd_count  in  CNT_W  step count for INC/DEC.
- q_fb  in  WIDTH  q outputs of the bank.
- j  out  WIDTH  registered J drive to the bank.
- k  out  WIDTH  registered K drive to the bank.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse at command completion.
- err  out  1  sticky error flag.

Behaviour:
- Reset (async, active-high):
  - j=0, k=0, busy=0, done=0, err=0, cmd_ready=1.
  - State forced to IDLE immediately, including mid-command; no partial pattern remains driven.
- Handshake:
  - Accept on the posedge where cmd_valid && cmd_ready.
  - cmd_ready = (state==IDLE).
  - Inputs are ignored while not ready and do not need to be held after acceptance.
- States: IDLE, DRIVE, SETTLE, STEP_DRIVE, STEP_SETTLE.
- Single-cycle ops (SET/CLEAR/TOGGLE/LOAD), accepted at edge E0:
  - After E0, state DRIVE and j/k are driven with the pattern below.
  - Bank captures at E1. After E1, state SETTLE, j=k=0 and done=1.
  - After E2, state IDLE and ready=1.
  - Throughput: one command per 3 cycles.
  - Patterns (m = cmd_mask, d = cmd_data):
    - SET: j=m, k=0.
    - CLEAR: j=0, k=m.
    - TOGGLE: j=m, k=m.
    - LOAD: j=d&m, k=~d&m.
    - Unmasked bits always get j=k=0 (hold).
- NOP: same DRIVE/SETTLE timing with j=k=0; clears err at acceptance.
- CHECK:
  - Same timing with j=k=0.
  - In SETTLE, if (q_fb^d)&m is nonzero, set err.
- INC/DEC, step counter loaded with cmd_count:
  - count==0: behaves as NOP timing, except err is not cleared.
  - Otherwise alternate STEP_DRIVE and STEP_SETTLE, 2 cycles per step.
  - In STEP_DRIVE: j=k=t, computed from q_fb sampled at the previous SETTLE, or at acceptance for the first step.
    - INC: t[0]=1, t[i]=&q_fb[i-1:0].
    - DEC: t[0]=1, t[i]=&~q_fb[i-1:0].
  - STEP_SETTLE drives j=k=0 and decrements the counter.
  - The last STEP_SETTLE asserts done, then IDLE.
  - Total latency after acceptance is 2N cycles.
  - Wrap-around is modular: all-ones INC gives zero; zero DEC gives all-ones. cmd_mask is ignored.
- err:
  - Sticky; set only by a CHECK mismatch or the optional verify.
  - Cleared only by reset or an accepted NOP.
  - A set and a clear cannot coincide, because each happens in a distinct cycle.
- done is never asserted in IDLE; busy = !cmd_ready.
- j and k are registered outputs with no combinational path from any input.

Optional Feature:
- Macro: JK_BANK_DRIVER_VERIFY_EN.
- Defined:
  - At acceptance of SET/CLEAR/TOGGLE/LOAD, compute expected = apply(op, q_fb).
  - In SETTLE, if q_fb != expected, set err.
  - For INC/DEC, each STEP_SETTLE checks q_fb == previous q_fb ±1 mod 2^WIDTH.
- Undefined: no expected register exists; err is set only by CHECK.
- All timing is identical in both builds.

Test Plan:
- Reset; LOAD m=0xFF d=0xA5 -> j=0xA5, k=0x5A for exactly one cycle, then j=k=0. q_fb reads 0xA5, done pulses 2 cycles after acceptance, ready returns next cycle.
- From q=0xA5: TOGGLE m=0x0F -> q=0xAA; SET m=0x40 -> 0xEA; CLEAR m=0x80 -> 0x6A. Unmasked bits always see j=k=0.
- LOAD 0xFE, then INC count=3 -> bank steps 0xFF, 0x00, 0x01. Six busy cycles; done on the 6th. DEC count=2 from 0x00 -> 0xFF, 0xFE.
- CHECK m=0xFF d=0x00 with q=0x01 -> err=1 and stays 1 through a following SET. NOP -> err=0.
- Assert reset during step 2 of INC count=5 -> j=k=0 immediately, busy=0, ready=1. The next command is accepted normally.
- VERIFY_EN build: force q_fb stuck at 0x00, SET m=0x01 -> err=1 in SETTLE. Non-VERIFY build: same stimulus -> err=0.
